// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush sequencer with memory-wait freeze and mult/div busy tracking
module hazard_ctrl #(
  parameter int MD_LATENCY  = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             IFID_rs,
  input  logic [4:0]             IFID_rt,
  input  logic                   IFID_use_rs,
  input  logic                   IFID_use_rt,
  input  logic                   IFID_branch,
  input  logic                   IFID_taken,
  input  logic                   IFID_use_hilo,
  input  logic                   IDEXE_RFWr,
  input  logic                   IDEXE_load,
  input  logic [4:0]             IDEXE_rd,
  input  logic                   IDEXE_md_start,
  input  logic                   EXEMEM_load,
  input  logic [4:0]             EXEMEM_rd,
  input  logic                   dm_req,
  input  logic                   dm_ready,
  output logic                   PCWrite,
  output logic                   IFID_stall,
  output logic                   IFID_flush,
  output logic                   IDEXE_stall,
  output logic                   IDEXE_flush,
  output logic                   EXEMEM_stall,
  output logic                   MEMWB_flush,
  output logic                   md_busy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  localparam int CW = $clog2(MD_LATENCY);
  localparam logic [CW-1:0] MD_LOAD = CW'(MD_LATENCY - 1);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t                 state_q, state_d;
  logic [CW-1:0]          md_cnt_q, md_cnt_d;
  logic                   md_busy_q, md_busy_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   hit_ex, hit_mem, lu, br1, br2, hl, frz, dep, tkn, start;
  function automatic logic reads(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic use_rs, input logic use_rt);
    return rd != 5'd0 && ((use_rs && rs == rd) || (use_rt && rt == rd));
  endfunction
  assign hit_ex  = reads(IDEXE_rd, IFID_rs, IFID_rt, IFID_use_rs, IFID_use_rt);
  assign hit_mem = reads(EXEMEM_rd, IFID_rs, IFID_rt, IFID_use_rs, IFID_use_rt);
  assign lu  = IDEXE_load & hit_ex;
  assign br1 = IFID_branch & IDEXE_RFWr & hit_ex;
  assign br2 = IFID_branch & EXEMEM_load & hit_mem;
  assign hl  = IFID_use_hilo & (md_busy_q | IDEXE_md_start);
  // Controls are forced idle while rst is high so nothing from a pre-reset freeze leaks out.
  assign frz   = !rst & dm_req & !dm_ready;
  assign dep   = !rst & (lu | br1 | br2 | hl);
  assign tkn   = !rst & IFID_taken;
  assign start = IDEXE_md_start & !frz;
  always_comb begin
    PCWrite      = !(frz | dep);
    IFID_stall   = frz | dep;
    IFID_flush   = !frz & !dep & tkn;
    IDEXE_stall  = frz;
    IDEXE_flush  = !frz & dep;
    EXEMEM_stall = frz;
    MEMWB_flush  = frz;
    state_d      = state_q == RUN ? (frz ? MEM_WAIT : RUN) : (dm_ready ? RUN : MEM_WAIT);
    md_cnt_d     = start ? MD_LOAD : (md_cnt_q != '0 ? md_cnt_q - CW'(1) : md_cnt_q);
    md_busy_d    = start | (md_busy_q & (md_cnt_q != CW'(1)));
    stall_cnt_d  = (!PCWrite && !(&stall_cnt_q)) ? stall_cnt_q + STALL_CNT_W'(1) : stall_cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      md_cnt_q    <= '0;
      md_busy_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      md_busy_q   <= md_busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign md_busy   = md_busy_q;
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl with MD_LATENCY=4 and a 4-bit stall counter
module tb_hazard_ctrl;
  localparam logic [6:0] RUNV  = 7'b1000000;
  localparam logic [6:0] DEPV  = 7'b0100100;
  localparam logic [6:0] TAKV  = 7'b1010000;
  localparam logic [6:0] FRZV  = 7'b0101011;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] IFID_rs, IFID_rt, IDEXE_rd, EXEMEM_rd;
  logic IFID_use_rs, IFID_use_rt, IFID_branch, IFID_taken, IFID_use_hilo;
  logic IDEXE_RFWr, IDEXE_load, IDEXE_md_start, EXEMEM_load, dm_req, dm_ready;
  logic PCWrite, IFID_stall, IFID_flush, IDEXE_stall, IDEXE_flush, EXEMEM_stall, MEMWB_flush, md_busy;
  logic [3:0] stall_cnt;
  typedef struct {
    string      tag;
    logic [6:0] ctrl;
    logic       busy;
    logic [3:0] sc;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_pass = 0;
  logic [3:0] exp_sc = '0;
  hazard_ctrl #(.MD_LATENCY(4), .STALL_CNT_W(4)) dut (
    .clk(clk), .rst(rst), .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .IFID_use_rs(IFID_use_rs),
    .IFID_use_rt(IFID_use_rt), .IFID_branch(IFID_branch), .IFID_taken(IFID_taken),
    .IFID_use_hilo(IFID_use_hilo), .IDEXE_RFWr(IDEXE_RFWr), .IDEXE_load(IDEXE_load),
    .IDEXE_rd(IDEXE_rd), .IDEXE_md_start(IDEXE_md_start), .EXEMEM_load(EXEMEM_load),
    .EXEMEM_rd(EXEMEM_rd), .dm_req(dm_req), .dm_ready(dm_ready), .PCWrite(PCWrite),
    .IFID_stall(IFID_stall), .IFID_flush(IFID_flush), .IDEXE_stall(IDEXE_stall),
    .IDEXE_flush(IDEXE_flush), .EXEMEM_stall(EXEMEM_stall), .MEMWB_flush(MEMWB_flush),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic idle();
    rst = 1'b0; IFID_rs = '0; IFID_rt = '0; IDEXE_rd = '0; EXEMEM_rd = '0;
    IFID_use_rs = 0; IFID_use_rt = 0; IFID_branch = 0; IFID_taken = 0; IFID_use_hilo = 0;
    IDEXE_RFWr = 0; IDEXE_load = 0; IDEXE_md_start = 0; EXEMEM_load = 0; dm_req = 0; dm_ready = 0;
  endtask
  // Inputs are already driven; queue the expectation, then sample 1 time unit later.
  task automatic step(input string tag, input logic [6:0] ctrl, input logic busy);
    exp_t e;
    if (rst) exp_sc = '0;
    sb.push_back('{tag, ctrl, busy, exp_sc});
    #1;
    e = sb.pop_front();
    chk({e.tag, ".ctrl"}, {PCWrite, IFID_stall, IFID_flush, IDEXE_stall, IDEXE_flush, EXEMEM_stall, MEMWB_flush}, e.ctrl);
    chk({e.tag, ".busy"}, md_busy, e.busy);
    chk({e.tag, ".sc"}, stall_cnt, e.sc);
    if (!rst && !e.ctrl[6] && exp_sc != 4'hF) exp_sc++;
    @(negedge clk);
  endtask
  initial begin
    idle(); rst = 1'b1;
    step("reset", RUNV, 0);
    idle(); step("idle", RUNV, 0);
    idle(); IDEXE_load = 1; IDEXE_rd = 2; IFID_use_rs = 1; IFID_rs = 2; step("lu_rs", DEPV, 0);
    idle(); step("lu_release", RUNV, 0);
    idle(); IDEXE_load = 1; IDEXE_rd = 5; IFID_use_rt = 1; IFID_rt = 5; step("lu_rt", DEPV, 0);
    idle(); IDEXE_load = 1; IDEXE_rd = 2; IFID_rs = 2; step("lu_nouse", RUNV, 0);
    idle(); IDEXE_load = 1; IDEXE_rd = 0; IFID_use_rs = 1; IFID_rs = 0; step("lu_r0", RUNV, 0);
    idle(); IFID_branch = 1; IFID_taken = 1; IFID_use_rs = 1; IFID_rs = 3; step("taken", TAKV, 0);
    idle(); IFID_branch = 1; IFID_taken = 1; IFID_use_rs = 1; IFID_rs = 3; IDEXE_RFWr = 1; IDEXE_rd = 3;
    step("br1", DEPV, 0);
    idle(); IFID_branch = 1; IFID_taken = 1; IFID_use_rt = 1; IFID_rt = 7; EXEMEM_load = 1; EXEMEM_rd = 7;
    step("br2", DEPV, 0);
    idle(); IFID_use_rs = 1; IFID_rs = 3; IDEXE_RFWr = 1; IDEXE_rd = 3; step("alu_fwd", RUNV, 0);
    idle(); IFID_branch = 1; IFID_taken = 1; IFID_use_rs = 1; IFID_rs = 3; step("br_release", TAKV, 0);
    for (int i = 0; i < 3; i++) begin
      idle(); dm_req = 1; IDEXE_load = 1; IDEXE_rd = 4; IFID_use_rs = 1; IFID_rs = 4; IFID_taken = 1;
      step("freeze", FRZV, 0);
    end
    idle(); dm_req = 1; dm_ready = 1; step("mem_ready", RUNV, 0);
    idle(); IFID_use_hilo = 1; IDEXE_md_start = 1; step("hl_t0", DEPV, 0);
    for (int i = 1; i < 4; i++) begin
      idle(); IFID_use_hilo = 1; step("hl_wait", DEPV, 1);
    end
    idle(); IFID_use_hilo = 1; step("hl_issue", RUNV, 0);
    idle(); dm_req = 1; IDEXE_md_start = 1; step("md_frozen", FRZV, 0);
    idle(); IFID_use_hilo = 1; step("md_noload", RUNV, 0);
    idle(); IDEXE_md_start = 1; step("rs_t0", RUNV, 0);
    idle(); step("rs_t1", RUNV, 1);
    idle(); IDEXE_md_start = 1; step("rs_t2", RUNV, 1);
    for (int i = 3; i < 6; i++) begin
      idle(); step("rs_busy", RUNV, 1);
    end
    idle(); step("rs_done", RUNV, 0);
    for (int i = 0; i < 12; i++) begin
      idle(); dm_req = 1; step("sat", FRZV, 0);
    end
    idle(); step("sat_hold", RUNV, 0);
    idle(); dm_req = 1; step("pre_rst", FRZV, 0);
    idle(); dm_req = 1; rst = 1; step("rst_frz", RUNV, 0);
    idle(); step("post_rst", RUNV, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
